// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline stall / flush / redirect controller
//
// Purpose
//   Produces per-stage stall and flush masks for an NSTAGE-deep in-order
//   pipeline. It arbitrates PC redirect requests coming from the stages.
//   Index 0 is IF; a higher index means an older stage.
//   - A stall request at stage k stalls stage k and every younger stage.
//   - A redirect from stage s is issued in the first cycle that stage s is
//     not stalled. When issued, it flushes every stage younger than s for
//     FLUSH_HOLD cycles.
//   - A redirect that cannot issue yet is held in a one-entry pending slot.
//     If the pending redirect and a new one compete, the older stage wins.
//
// Parameters
//   NSTAGE      pipeline stage count (>= 2)
//   AW          redirect PC width
//   FLUSH_HOLD  cycles flush_o stays asserted per redirect (1..15)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   rdy            global ready; 0 freezes the whole pipeline
//   stall_req_i    per-stage stall request           [NSTAGE]
//   set_pc_e_i     redirect request valid
//   set_pc_i       redirect target PC                [AW]
//   redir_stage_i  index of the requesting stage     [$clog2(NSTAGE)]
//   stall_o        per-stage stall                   [NSTAGE]
//   flush_o        per-stage flush                   [NSTAGE]
//   set_pc_e_o     one-cycle redirect strobe to IF
//   set_pc_o       redirect PC, valid with set_pc_e_o
//   stall_cnt_o    (PIPE_CTRL_PERF_EN only) cycles with rdy=1 and any stall
//   redir_cnt_o    (PIPE_CTRL_PERF_EN only) number of issued redirects
//
// Configuration
//   Define PIPE_CTRL_PERF_EN to add the two 32-bit performance counters.
//   When the macro is undefined, neither the ports nor the counters exist.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int NSTAGE     = 5,
  parameter int AW         = 32,
  parameter int FLUSH_HOLD = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic [NSTAGE-1:0]         stall_req_i,
  input  logic                      set_pc_e_i,
  input  logic [AW-1:0]             set_pc_i,
  input  logic [$clog2(NSTAGE)-1:0] redir_stage_i,
  output logic [NSTAGE-1:0]         stall_o,
  output logic [NSTAGE-1:0]         flush_o,
  output logic                      set_pc_e_o,
  output logic [AW-1:0]             set_pc_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               redir_cnt_o
`endif
);

  localparam int SW = $clog2(NSTAGE);
  // FLUSH_HOLD is at most 15, so a 4-bit down-counter is enough.
  localparam logic [3:0] HOLD_LOAD = 4'(FLUSH_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [AW-1:0]     pend_pc_q, pend_pc_d;
  logic [SW-1:0]     pend_stage_q, pend_stage_d;
  logic [3:0]        flush_cnt_q, flush_cnt_d;
  logic [NSTAGE-1:0] flush_mask_q, flush_mask_d;

  // ---------------------------------------------------------------------------
  // Stall mask: bit i is set if any stage at index i or older requests a stall.
  // The result is an OR over the suffix of stall_req_i.
  // ---------------------------------------------------------------------------
  logic [NSTAGE-1:0] stall_mask;

  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stall
      assign stall_mask[gi] = |stall_req_i[NSTAGE-1:gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Arbitration between the incoming redirect and the pending one
  // ---------------------------------------------------------------------------
  logic              pend_v;
  logic              take_in;
  logic              win_v;
  logic [AW-1:0]     win_pc;
  logic [SW-1:0]     win_stage;
  logic              win_blocked;
  logic              issue;
  logic [NSTAGE-1:0] issue_mask;

  assign pend_v = (state_q == PEND);

  always_comb begin
    // Defaults first.
    stall_o     = '1;
    take_in     = 1'b0;
    win_v       = 1'b0;
    win_pc      = pend_pc_q;
    win_stage   = pend_stage_q;
    win_blocked = 1'b0;
    issue       = 1'b0;
    issue_mask  = '0;

    // Stall the whole pipeline while in reset or when rdy is low.
    if (!rst && rdy) begin
      stall_o = stall_mask;
    end

    // The input wins on an equal stage index. Otherwise the older stage wins.
    take_in = set_pc_e_i && (!pend_v || (redir_stage_i >= pend_stage_q));
    win_v   = set_pc_e_i || pend_v;
    if (take_in) begin
      win_pc    = set_pc_i;
      win_stage = redir_stage_i;
    end

    // A stage index that is out of range selects no stall bit, so it is
    // never blocked.
    for (int i = 0; i < NSTAGE; i++) begin
      if (i == int'(win_stage)) begin
        win_blocked = stall_o[i];
      end
    end

    issue = win_v && rdy && !win_blocked && !rst;

    // Flush every stage younger than the redirecting stage.
    for (int i = 0; i < NSTAGE; i++) begin
      issue_mask[i] = (i < int'(win_stage));
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state, pending slot and flush hold
  // ---------------------------------------------------------------------------
  always_comb begin
    // Defaults first.
    state_d      = IDLE;
    pend_pc_d    = pend_pc_q;
    pend_stage_d = pend_stage_q;
    flush_cnt_d  = flush_cnt_q;
    flush_mask_d = flush_mask_q;

    case (state_q)
      IDLE, PEND: begin
        // The winner either issues now or takes over the pending slot.
        // The loser is dropped in both cases.
        if (win_v && !issue) begin
          state_d      = PEND;
          pend_pc_d    = win_pc;
          pend_stage_d = win_stage;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The issue cycle is the first flush cycle. The counter covers the
    // remaining FLUSH_HOLD-1 cycles. A new issue restarts the hold.
    // The count ignores stall_o and rdy.
    if (issue) begin
      flush_cnt_d  = HOLD_LOAD;
      flush_mask_d = issue_mask;
    end else if (flush_cnt_q != 4'd0) begin
      flush_cnt_d = flush_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_pc_q    <= '0;
      pend_stage_q <= '0;
      flush_cnt_q  <= 4'd0;
      flush_mask_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_pc_q    <= pend_pc_d;
      pend_stage_q <= pend_stage_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_mask_q <= flush_mask_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    set_pc_e_o = issue;
    set_pc_o   = issue ? win_pc : '0;
    flush_o    = '0;
    if (!rst) begin
      if (issue) begin
        flush_o = issue_mask;
      end else if (flush_cnt_q != 4'd0) begin
        flush_o = flush_mask_q;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters. Both wrap naturally at 2^32.
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(rdy && (stall_o != '0));
    redir_cnt_d = redir_cnt_q + 32'(set_pc_e_o);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign redir_cnt_o = redir_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (NSTAGE=5, FLUSH_HOLD=2)
//
// The reference model works at the transaction level. It keeps pending
// redirects in a queue, builds stall and flush masks with shift arithmetic,
// and tracks the flush hold as a count of remaining cycles.
// Define PIPE_CTRL_PERF_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int NSTAGE = 5;
  localparam int AW     = 32;
  localparam int HOLD   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic [NSTAGE-1:0] stall_req_i;
  logic              set_pc_e_i;
  logic [AW-1:0]     set_pc_i;
  logic [2:0]        redir_stage_i;
  logic [NSTAGE-1:0] stall_o;
  logic [NSTAGE-1:0] flush_o;
  logic              set_pc_e_o;
  logic [AW-1:0]     set_pc_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]       stall_cnt_o;
  logic [31:0]       redir_cnt_o;
  int unsigned       m_scnt, m_rcnt;
  logic [31:0]       obs_scnt, obs_rcnt;
`endif

  pipe_ctrl #(.NSTAGE(NSTAGE), .AW(AW), .FLUSH_HOLD(HOLD)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .stall_req_i  (stall_req_i),
    .set_pc_e_i   (set_pc_e_i),
    .set_pc_i     (set_pc_i),
    .redir_stage_i(redir_stage_i),
    .stall_o      (stall_o),
    .flush_o      (flush_o),
    .set_pc_e_o   (set_pc_e_o),
    .set_pc_o     (set_pc_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt_o),
    .redir_cnt_o  (redir_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    int          s;
  } redir_t;

  redir_t pend_q[$];
  int     m_frem  = 0;
  int     m_fmask = 0;

  logic [31:0] obs_stall, obs_flush, obs_pc;
  logic        obs_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one clock cycle. At the negedge it checks the outputs against the
  // model, then it advances the model to match the coming posedge.
  task automatic step(input string tag);
    int     k;
    int     exp_stall, exp_flush;
    bit     exp_e, win_v, eff;
    logic [31:0] exp_pc;
    redir_t win;
    win = '{pc: 32'd0, s: 0};
    win_v = 1'b0;
    eff = 1'b0;
    @(negedge clk);
    if (rst) begin
      exp_stall = 31; exp_flush = 0; exp_e = 1'b0; exp_pc = 32'd0;
    end else begin
      if (!rdy) exp_stall = 31;
      else begin
        k = -1;
        for (int i = 0; i < NSTAGE; i++) if (stall_req_i[i]) k = i;
        exp_stall = (1 << (k + 1)) - 1;
      end
      if (pend_q.size() > 0) begin
        win = pend_q[0];
        win_v = 1'b1;
      end
      if (set_pc_e_i && (!win_v || int'(redir_stage_i) >= win.s)) begin
        win.pc = set_pc_i;
        win.s = int'(redir_stage_i);
        win_v = 1'b1;
      end
      eff = win_v && rdy && !exp_stall[win.s];
      exp_e = eff;
      exp_pc = eff ? win.pc : 32'd0;
      exp_flush = eff ? ((1 << win.s) - 1) : ((m_frem > 0) ? m_fmask : 0);
    end

    obs_stall = 32'(stall_o);
    obs_flush = 32'(flush_o);
    obs_e     = set_pc_e_o;
    obs_pc    = set_pc_o;
    chk({tag, "/stall"}, obs_stall, exp_stall);
    chk({tag, "/flush"}, obs_flush, exp_flush);
    chk({tag, "/pc_e"}, 32'(obs_e), 32'(exp_e));
    if (exp_e || rst) chk({tag, "/pc"}, obs_pc, exp_pc);
`ifdef PIPE_CTRL_PERF_EN
    obs_scnt = stall_cnt_o;
    obs_rcnt = redir_cnt_o;
    if (!rst) begin
      chk({tag, "/scnt"}, obs_scnt, m_scnt);
      chk({tag, "/rcnt"}, obs_rcnt, m_rcnt);
    end
`endif

    if (rst) begin
      pend_q.delete();
      m_frem = 0;
`ifdef PIPE_CTRL_PERF_EN
      m_scnt = 0; m_rcnt = 0;
`endif
    end else begin
      if (eff) begin
        m_frem = HOLD - 1;
        m_fmask = exp_flush;
      end else if (m_frem > 0) m_frem--;
      pend_q.delete();
      if (win_v && !eff) pend_q.push_back(win);
`ifdef PIPE_CTRL_PERF_EN
      if (rdy && exp_stall != 0) m_scnt++;
      if (eff) m_rcnt++;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [2:0] s, input logic [31:0] pc);
    set_pc_e_i = 1'b1; redir_stage_i = s; set_pc_i = pc;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; stall_req_i = '0;
    set_pc_e_i = 1'b0; set_pc_i = '0; redir_stage_i = '0;

    // Reset state
    step("reset");
    redir(3'd2, 32'h55);
    step("reset_ign");
    chk("reset_stall", obs_stall, 32'h1f);
    chk("reset_pc_e", 32'(obs_e), 32'd0);
    set_pc_e_i = 1'b0;
    rst = 1'b0;

    // Stall masks
    stall_req_i = 5'b01000; step("st1"); chk("st_01000", obs_stall, 32'h0f);
    stall_req_i = 5'b00010; step("st2"); chk("st_00010", obs_stall, 32'h03);
    stall_req_i = 5'b01010; step("st3"); chk("st_01010", obs_stall, 32'h0f);
    rdy = 1'b0;             step("st4"); chk("st_rdy0", obs_stall, 32'h1f);
    rdy = 1'b1; stall_req_i = '0;
    step("st5");            chk("st_none", obs_stall, 32'h00);

    // Zero-latency redirect with a two-cycle flush
    redir(3'd2, 32'h100);
    step("r35a");
    chk("r35_e", 32'(obs_e), 32'd1);
    chk("r35_pc", obs_pc, 32'h100);
    chk("r35_fl0", obs_flush, 32'h03);
    set_pc_e_i = 1'b0;
    step("r35b"); chk("r35_fl1", obs_flush, 32'h03);
    step("r35c"); chk("r35_fl2", obs_flush, 32'h00);

    // Redirect held back by a stall
    stall_req_i = 5'b01000; redir(3'd1, 32'h1a0);
    step("r36a"); chk("r36_hold0", 32'(obs_e), 32'd0);
    set_pc_e_i = 1'b0;
    step("r36b"); chk("r36_hold1", 32'(obs_e), 32'd0);
    step("r36c"); chk("r36_hold2", 32'(obs_e), 32'd0);
    stall_req_i = '0;
    step("r36d");
    chk("r36_e", 32'(obs_e), 32'd1);
    chk("r36_pc", obs_pc, 32'h1a0);
    step("r36e"); chk("r36_once", 32'(obs_e), 32'd0);

    // An older input redirect replaces the pending one
    stall_req_i = 5'b00010; redir(3'd1, 32'h200);
    step("r37a");
    stall_req_i = '0; redir(3'd3, 32'h300);
    step("r37b");
    chk("r37_e", 32'(obs_e), 32'd1);
    chk("r37_pc", obs_pc, 32'h300);
    chk("r37_fl", obs_flush, 32'h07);
    set_pc_e_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("r37c"); chk("r37_no200", 32'(obs_e), 32'd0);
    end

    // Reset drops a pending redirect
    stall_req_i = 5'b01000; redir(3'd2, 32'h380);
    step("r38a");
    set_pc_e_i = 1'b0; rst = 1'b1;
    step("r38b"); step("r38c");
    rst = 1'b0; stall_req_i = '0;
    step("r38d");
    chk("r38_e", 32'(obs_e), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk("r38_scnt0", obs_scnt, 32'd0);
    chk("r38_rcnt0", obs_rcnt, 32'd0);
`endif
    step("r38e"); chk("r38_e2", 32'(obs_e), 32'd0);

`ifdef PIPE_CTRL_PERF_EN
    // Seven stalled cycles plus two redirects
    rst = 1'b1; step("p39r"); rst = 1'b0;
    stall_req_i = 5'b00001;
    for (int i = 0; i < 7; i++) step("p39s");
    stall_req_i = '0;
    redir(3'd0, 32'h10); step("p39a");
    set_pc_e_i = 1'b0;   step("p39b");
    redir(3'd0, 32'h20); step("p39c");
    set_pc_e_i = 1'b0;   step("p39d");
    chk("p39_scnt", obs_scnt, 32'd7);
    chk("p39_rcnt", obs_rcnt, 32'd2);
`endif

    // Random traffic checked against the model
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      stall_req_i = '0;
      for (int i = 0; i < NSTAGE; i++)
        stall_req_i[i] = ($urandom_range(0, 9) == 0);
      set_pc_e_i = ($urandom_range(0, 2) == 0);
      redir_stage_i = 3'($urandom_range(0, NSTAGE - 1));
      set_pc_i = $urandom;
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
